cpu_datapath: RTL and testbench

//  Datapath that consumes the controller's control bus and returns opCode/D/CF/ZF to it.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/cpu_alu.sv | 43 ++++
 rtl/cpu_datapath.sv | 97 +++++++++
 tb/tb_cpu_datapath.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the CPU datapath and controller: ALU function codes,
// instruction opcodes and instruction-register field layout.
package cpu_pkg;

    localparam logic [3:0] ALU_PASS_B = 4'd0;
    localparam logic [3:0] ALU_ADD    = 4'd1;
    localparam logic [3:0] ALU_SUB    = 4'd2;
    localparam logic [3:0] ALU_AND    = 4'd3;
    localparam logic [3:0] ALU_OR     = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_NOT_A  = 4'd6;
    localparam logic [3:0] ALU_INC_A  = 4'd7;
    localparam logic [3:0] ALU_DEC_A  = 4'd8;
    localparam logic [3:0] ALU_SHL_A  = 4'd9;
    localparam logic [3:0] ALU_SHR_A  = 4'd10;

    localparam logic [4:0] OP_MOVLA  = 5'b00000;
    localparam logic [4:0] OP_MOVAR  = 5'b00010;
    localparam logic [4:0] OP_MOVIRA = 5'b00011;
    localparam logic [4:0] OP_MOVIAR = 5'b00100;
    localparam logic [4:0] OP_JZ     = 5'b10110;

    // Field positions above the literal, which occupies IR[DATA_W-1:0].
    localparam int OPC_W      = 5;
    localparam int IR_D_OFS   = 0;
    localparam int IR_OPC_OFS = 1;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: computes a DATA_W+1 wide result whose top bit is the
// carry/borrow, plus a zero flag on the DATA_W-bit result.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] y,
    output logic              c,
    output logic              z
);

    localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

    logic [DATA_W:0] wide;

    always_comb begin
        wide = {1'b0, a};
        case (op)
            ALU_PASS_B: wide = {1'b0, b};
            ALU_ADD:    wide = {1'b0, a} + {1'b0, b};
            ALU_SUB:    wide = {1'b0, a} - {1'b0, b};
            ALU_AND:    wide = {1'b0, a & b};
            ALU_OR:     wide = {1'b0, a | b};
            ALU_XOR:    wide = {1'b0, a ^ b};
            ALU_NOT_A:  wide = {1'b0, ~a};
            ALU_INC_A:  wide = {1'b0, a} + ONE;
            ALU_DEC_A:  wide = {1'b0, a} - ONE;
            ALU_SHL_A:  wide = {a, 1'b0};
            // Shifted-out LSB lands in the carry position.
            ALU_SHR_A:  wide = {a[0], 1'b0, a[DATA_W-1:1]};
            default:    wide = {1'b0, a};
        endcase
    end

    assign y = wide[DATA_W-1:0];
    assign c = wide[DATA_W];
    assign z = (y == '0);

endmodule

// File: rtl/cpu_datapath.sv
// CPU datapath: PC, IR, accumulator, MDR and flags, driven by the controller's
// control bus, with program-memory and RAM ports.
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic                CLK,
    input  logic                Reset_in,
    input  logic                ALU_MUX,
    input  logic [3:0]          ALU_OP,
    input  logic                ALU_EN,
    input  logic                PC_INC,
    input  logic                PC_LOAD,
    input  logic                IR_WR_CLK,
    input  logic                RAM_WR,
    input  logic                RAM_RD,
    input  logic                FLAG_WR_CLK,
    input  logic                RAM_MUX,
    input  logic                MDR_WR_CLK,
    input  logic                A_WR_CLK,
    input  logic [DATA_W+5:0]   imem_data,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [4:0]          opCode,
    output logic                D,
    output logic                CF,
    output logic                ZF,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_we,
    output logic                mem_re,
    output logic [DATA_W-1:0]   A_out
);

    logic [ADDR_W-1:0] pc;
    logic [DATA_W+5:0] ir;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mdr;
    logic              cf;
    logic              zf;

    logic [DATA_W-1:0] literal;
    logic [DATA_W-1:0] b_opnd;
    logic [DATA_W-1:0] alu_y;
    logic              alu_c;
    logic              alu_z;
    logic [DATA_W-1:0] y;

    assign literal = ir[DATA_W-1:0];
    assign b_opnd  = ALU_MUX ? mdr : literal;
    assign y       = ALU_EN ? alu_y : b_opnd;

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a  (acc),
        .b  (b_opnd),
        .op (ALU_OP),
        .y  (alu_y),
        .c  (alu_c),
        .z  (alu_z)
    );

    always_ff @(posedge CLK) begin
        if (!Reset_in) begin
            pc  <= '0;
            ir  <= '0;
            acc <= '0;
            mdr <= '0;
            cf  <= 1'b0;
            zf  <= 1'b0;
        end else begin
            if (PC_LOAD)      pc  <= literal;
            else if (PC_INC)  pc  <= pc + 1'b1;
            if (IR_WR_CLK)    ir  <= imem_data;
            if (A_WR_CLK)     acc <= y;
            if (MDR_WR_CLK)   mdr <= mem_rdata;
            // Flags only reflect real ALU results, never a plain B pass-through.
            if (FLAG_WR_CLK && ALU_EN) begin
                cf <= alu_c;
                zf <= alu_z;
            end
        end
    end

    assign opCode    = ir[DATA_W+IR_OPC_OFS +: OPC_W];
    assign D         = ir[DATA_W+IR_D_OFS];
    assign CF        = cf;
    assign ZF        = zf;
    assign imem_addr = pc;
    assign mem_addr  = RAM_MUX ? mdr : literal;
    assign mem_wdata = acc;
    assign mem_we    = RAM_WR & Reset_in;
    assign mem_re    = RAM_RD & ~RAM_WR & Reset_in;
    assign A_out     = acc;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed self-checking bench for cpu_datapath: reset, fetch, ALU/flags,
// indirect RAM access, PC wrap/priority and reset in the middle of a write.
module tb_cpu_datapath;
    import cpu_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset_in;
    logic        ALU_MUX, ALU_EN, PC_INC, PC_LOAD, IR_WR_CLK, RAM_WR, RAM_RD;
    logic        FLAG_WR_CLK, RAM_MUX, MDR_WR_CLK, A_WR_CLK;
    logic [3:0]  ALU_OP;
    logic [13:0] imem_data;
    logic [7:0]  mem_rdata;
    logic [4:0]  opCode;
    logic        D, CF, ZF, mem_we, mem_re;
    logic [7:0]  imem_addr, mem_addr, mem_wdata, A_out;

    int checks = 0;
    int errors = 0;

    cpu_datapath dut (
        .CLK(CLK), .Reset_in(Reset_in), .ALU_MUX(ALU_MUX), .ALU_OP(ALU_OP),
        .ALU_EN(ALU_EN), .PC_INC(PC_INC), .PC_LOAD(PC_LOAD), .IR_WR_CLK(IR_WR_CLK),
        .RAM_WR(RAM_WR), .RAM_RD(RAM_RD), .FLAG_WR_CLK(FLAG_WR_CLK), .RAM_MUX(RAM_MUX),
        .MDR_WR_CLK(MDR_WR_CLK), .A_WR_CLK(A_WR_CLK), .imem_data(imem_data),
        .mem_rdata(mem_rdata), .opCode(opCode), .D(D), .CF(CF), .ZF(ZF),
        .imem_addr(imem_addr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .A_out(A_out)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ctrl(input logic v);
        ALU_MUX = v; ALU_EN = v; PC_INC = v; PC_LOAD = v; IR_WR_CLK = v;
        RAM_WR = v; RAM_RD = v; FLAG_WR_CLK = v; RAM_MUX = v; MDR_WR_CLK = v;
        A_WR_CLK = v; ALU_OP = v ? 4'hF : 4'h0;
    endtask

    task automatic load_ir(input logic [13:0] word);
        imem_data = word;
        IR_WR_CLK = 1'b1;
        step();
        IR_WR_CLK = 1'b0;
    endtask

    task automatic load_a(input logic [7:0] val);
        load_ir({5'b00000, 1'b0, val});
        ALU_EN = 1'b0; ALU_MUX = 1'b0; A_WR_CLK = 1'b1;
        step();
        A_WR_CLK = 1'b0;
    endtask

    task automatic alu_step(input logic [3:0] op, input logic [7:0] lit,
                            input logic en, input logic flag);
        load_ir({5'b00000, 1'b0, lit});
        ALU_OP = op; ALU_EN = en; FLAG_WR_CLK = flag; ALU_MUX = 1'b0; A_WR_CLK = 1'b1;
        step();
        ALU_EN = 1'b0; FLAG_WR_CLK = 1'b0; A_WR_CLK = 1'b0; ALU_OP = 4'h0;
    endtask

    task automatic test_reset();
        Reset_in = 1'b0;
        set_ctrl(1'b1);
        imem_data = 14'h3FFF;
        mem_rdata = 8'hA5;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (mem_we !== 1'b0 || mem_re !== 1'b0) begin
                errors++;
                $display("FAIL reset_mem_strobes cycle %0d: we=%b re=%b, need 0 0", i, mem_we, mem_re);
            end
            step();
        end
        checks++;
        if (mem_we !== 1'b0 || mem_re !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem_strobes_after: we=%b re=%b, need 0 0", mem_we, mem_re);
        end
        checks++;
        if ({opCode, D, CF, ZF} !== 8'h00 || A_out !== 8'h00 || mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs: op=%h D=%b CF=%b ZF=%b A=%h wdata=%h, need all 0",
                     opCode, D, CF, ZF, A_out, mem_wdata);
        end
        checks++;
        if (mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_mdr: mem_addr=%h via MDR, need 00", mem_addr);
        end
        set_ctrl(1'b0);
        Reset_in = 1'b1;
        step();
        checks++;
        if (imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_release_pc: pc=%h, need 00", imem_addr);
        end
    endtask

    task automatic test_fetch();
        imem_data = {5'b00111, 1'b1, 8'h5A};
        IR_WR_CLK = 1'b1; PC_INC = 1'b1;
        step();
        IR_WR_CLK = 1'b0; PC_INC = 1'b0; RAM_MUX = 1'b0;
        #1;
        checks++;
        if (opCode !== 5'b00111 || D !== 1'b1) begin
            errors++;
            $display("FAIL fetch_ir: op=%b D=%b, need 00111 1", opCode, D);
        end
        checks++;
        if (imem_addr !== 8'h01 || mem_addr !== 8'h5A) begin
            errors++;
            $display("FAIL fetch_pc_addr: pc=%h addr=%h, need 01 5a", imem_addr, mem_addr);
        end
    endtask

    task automatic test_alu_flags();
        logic [7:0] exp_a [7];
        logic [1:0] exp_f [7];
        logic [3:0] ops   [7];
        logic [7:0] lits  [7];
        logic       ens   [7];
        logic       flgs  [7];
        // A=FF+01 -> 00 C1 Z1; +01 no flag write -> 01 hold; 01-02 -> FF borrow;
        // FF^FF -> 00; pass literal 07 with ALU_EN=0 -> flags hold; 07>>1 -> 03 C1;
        // 03-1 -> 02; ~02 -> FD.
        ops  = '{ALU_ADD, ALU_ADD, ALU_SUB, ALU_XOR, ALU_ADD, ALU_SHR_A, ALU_DEC_A};
        lits = '{8'h01, 8'h01, 8'h02, 8'hFF, 8'h07, 8'h00, 8'h00};
        ens  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        flgs = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_a = '{8'h00, 8'h01, 8'hFF, 8'h00, 8'h07, 8'h03, 8'h02};
        exp_f = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00};
        load_a(8'hFF);
        checks++;
        if (A_out !== 8'hFF) begin
            errors++;
            $display("FAIL alu_load_a: A=%h, need ff", A_out);
        end
        for (int i = 0; i < 7; i++) begin
            alu_step(ops[i], lits[i], ens[i], flgs[i]);
            checks++;
            if (A_out !== exp_a[i] || {CF, ZF} !== exp_f[i]) begin
                errors++;
                $display("FAIL alu_vec%0d: A=%h CF=%b ZF=%b, need A=%h CF=%b ZF=%b",
                         i, A_out, CF, ZF, exp_a[i], exp_f[i][1], exp_f[i][0]);
            end
        end
        alu_step(ALU_NOT_A, 8'h00, 1'b1, 1'b1);
        checks++;
        if (A_out !== 8'hFD || {CF, ZF} !== 2'b00) begin
            errors++;
            $display("FAIL alu_not: A=%h CF=%b ZF=%b, need fd 0 0", A_out, CF, ZF);
        end
    endtask

    task automatic test_indirect();
        mem_rdata = 8'h20; RAM_RD = 1'b1; MDR_WR_CLK = 1'b1;
        #1;
        checks++;
        if (mem_re !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL indirect_read_strobe: re=%b we=%b, need 1 0", mem_re, mem_we);
        end
        step();
        RAM_RD = 1'b0; MDR_WR_CLK = 1'b0;
        load_a(8'h33);
        RAM_MUX = 1'b1; RAM_WR = 1'b1; RAM_RD = 1'b1;
        #1;
        checks++;
        if (mem_addr !== 8'h20 || mem_wdata !== 8'h33) begin
            errors++;
            $display("FAIL indirect_addr_data: addr=%h wdata=%h, need 20 33", mem_addr, mem_wdata);
        end
        checks++;
        if (mem_we !== 1'b1 || mem_re !== 1'b0) begin
            errors++;
            $display("FAIL indirect_write_wins: we=%b re=%b, need 1 0", mem_we, mem_re);
        end
        RAM_WR = 1'b0;
        mem_rdata = 8'h44; MDR_WR_CLK = 1'b1;
        #1;
        checks++;
        if (mem_addr !== 8'h20 || mem_re !== 1'b1) begin
            errors++;
            $display("FAIL indirect_old_mdr: addr=%h re=%b, need 20 1", mem_addr, mem_re);
        end
        step();
        MDR_WR_CLK = 1'b0; RAM_RD = 1'b0;
        checks++;
        if (mem_addr !== 8'h44) begin
            errors++;
            $display("FAIL indirect_new_mdr: addr=%h, need 44", mem_addr);
        end
        RAM_MUX = 1'b0;
    endtask

    task automatic test_pc();
        load_ir({5'b00000, 1'b0, 8'hFF});
        PC_LOAD = 1'b1;
        step();
        PC_LOAD = 1'b0;
        checks++;
        if (imem_addr !== 8'hFF) begin
            errors++;
            $display("FAIL pc_load: pc=%h, need ff", imem_addr);
        end
        PC_INC = 1'b1;
        step();
        PC_INC = 1'b0;
        checks++;
        if (imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h, need 00", imem_addr);
        end
        load_ir({5'b00000, 1'b0, 8'h40});
        PC_LOAD = 1'b1; PC_INC = 1'b1;
        step();
        PC_LOAD = 1'b0; PC_INC = 1'b0;
        checks++;
        if (imem_addr !== 8'h40) begin
            errors++;
            $display("FAIL pc_load_priority: pc=%h, need 40", imem_addr);
        end
        step();
        checks++;
        if (imem_addr !== 8'h40) begin
            errors++;
            $display("FAIL pc_hold: pc=%h, need 40", imem_addr);
        end
    endtask

    task automatic test_reset_midop();
        RAM_WR = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b1 || A_out !== 8'h33) begin
            errors++;
            $display("FAIL midop_pre: we=%b A=%h, need 1 33", mem_we, A_out);
        end
        Reset_in = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_re !== 1'b0) begin
            errors++;
            $display("FAIL midop_we_gate: we=%b re=%b, need 0 0", mem_we, mem_re);
        end
        step();
        checks++;
        if (A_out !== 8'h00 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL midop_clear: A=%h pc=%h, need 00 00", A_out, imem_addr);
        end
        RAM_WR = 1'b0;
        Reset_in = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_alu_flags();
        test_indirect();
        test_pc();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
